pixie_dma_sched: RTL and testbench
==================================

Name: pixie_dma_sched

Overview:
- Sequences CDP1861-style display DMA between the CPU core and the pixie frame buffer.
- On each active video line it requests a fixed-length DMA burst via DMAO.
- It counts the CPU's DMA cycles (SC state 2'b10), turns each accepted byte into a frame-buffer write, and generates the frame interrupt (INT) and the EFx flag windows.
- It sits between the CPU core, the video timing generator (which supplies line_start/vpos) and the frame buffer write port.

Parameters:
- BYTES_PER_LINE, 8: DMA bytes per active line.
- ACTIVE_FIRST, 64: first active line number (vpos).
- ACTIVE_LINES, 128: number of active lines per frame.
- INT_LEAD, 2: lines before ACTIVE_FIRST at which INT asserts.
- EF_LINES, 4: length in lines of each EFx low window.
- FB_AW, 10: frame buffer address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_enable  in  1  CPU machine-cycle strobe; SC, disp_on and disp_off are sampled only when this is high
- SC  in  2  CPU state code: 00 fetch, 01 execute, 10 DMA, 11 interrupt
- disp_on  in  1  display enable request
- disp_off  in  1  display disable request
- line_start  in  1  one-clk pulse at the start of each line, from video timing
- vpos  in  9  current line number, valid when line_start is high
- data_in  in  8  CPU data bus during a DMA cycle
- DMAO  out  1  DMA-out request, active low
- INT  out  1  interrupt request, active high
- EFx  out  1  display flag, active low
- fb_wr_en  out  1  one-clk frame buffer write strobe
- fb_wr_addr  out  FB_AW  frame buffer write address
- fb_wr_data  out  8  frame buffer write data
- enabled  out  1  display enabled status
- overrun  out  1  sticky flag: a burst was truncated by the next line_start

Behaviour:
- Reset: DMAO=1, INT=0, EFx=1, fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, enabled=0, overrun=0, state=IDLE.
- Enable control, on a clk_enable cycle:
  - disp_on sets enabled; disp_off clears it.
  - If both are high, disp_on wins.
- Active line: line_start with ACTIVE_FIRST <= vpos <= ACTIVE_FIRST+ACTIVE_LINES-1.
- States: IDLE, WAIT_LINE, BURST.
- IDLE:
  - Entered whenever enabled=0.
  - DMAO=1; INT and EFx keep running (timing-only).
  - Leaves to WAIT_LINE on the clk after enabled becomes 1.
- WAIT_LINE:
  - On an active line_start: go to BURST; DMAO goes low on the next clk; byte_cnt=0.
  - If vpos==ACTIVE_FIRST on that line_start, fb_wr_addr is also reset to 0.
- BURST, each clk_enable cycle with SC==2'b10:
  - fb_wr_en pulses for exactly one clk; fb_wr_data=data_in, registered, 1-clk latency.
  - fb_wr_addr increments by 1 the clk after the write, mod 2^FB_AW.
  - byte_cnt increments.
- BURST end:
  - When the BYTES_PER_LINE-th byte is accepted, DMAO returns high on the same clk the write strobe asserts; state=WAIT_LINE.
  - SC==10 outside BURST never produces a write.
- Truncation:
  - A line_start while in BURST sets overrun (cleared only by reset).
  - The unfinished count is discarded and the new line is evaluated as in WAIT_LINE.
- disp_off mid-burst: DMAO=1 on the next clk, no further writes, state=IDLE, fb_wr_addr is held.
- INT:
  - Set on line_start with vpos==ACTIVE_FIRST-INT_LEAD.
  - Cleared on line_start with vpos==ACTIVE_FIRST, or on a clk_enable cycle with SC==2'b11 (acknowledge), whichever comes first.
  - INT asserts only while enabled=1.
- EFx:
  - Low from line_start of vpos==ACTIVE_FIRST-EF_LINES up to line_start of vpos==ACTIVE_FIRST.
  - Low again from line_start of vpos==ACTIVE_FIRST+ACTIVE_LINES-EF_LINES up to line_start of vpos==ACTIVE_FIRST+ACTIVE_LINES.
  - High otherwise; independent of enabled.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then disp_on, run one frame with the CPU answering 8 DMA cycles per line -> 1024 fb_wr_en pulses at addresses 0..1023, fb_wr_addr wraps to 0, overrun=0.
- Active line where the CPU answers only 5 DMA cycles before the next line_start -> overrun=1, 5 writes, the next burst starts at that address+5.
- disp_off after the 3rd byte of a burst -> DMAO high within 1 clk, no 4th write, enabled=0, INT never set in later frames.
- Enabled frame with no acknowledge -> INT high from line 62 to line 64 start; with SC=11 on line 63 -> INT low the next clk.
- EFx check -> low during lines 60..63 and 188..191, high on lines 59, 64 and 192.
- disp_on and disp_off together on one clk_enable -> enabled=1; SC=10 with DMAO high -> no write.

Source files
------------

// File: rtl/pixie_dma_sched.sv
// pixie_dma_sched: sequences display DMA between the CPU core and the pixie
// frame buffer. Each active video line gets one fixed-length DMA burst. Each
// accepted byte becomes one frame-buffer write. The block also produces the
// frame interrupt and the EFx flag windows.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   clk_enable         CPU machine-cycle strobe (qualifies SC, disp_on, disp_off)
//   SC                 CPU state code (10 = DMA cycle, 11 = interrupt acknowledge)
//   disp_on, disp_off  display enable / disable requests
//   line_start, vpos   line pulse and line number from video timing
//   data_in            CPU data bus during DMA
//   DMAO               DMA-out request, active low
//   INT                frame interrupt, active high
//   EFx                display flag, active low
//   fb_wr_en/addr/data frame-buffer write port
//   enabled            display enable status
//   overrun            sticky: a burst was cut short by the next line_start
module pixie_dma_sched #(
    parameter int unsigned BYTES_PER_LINE = 8,
    parameter int unsigned ACTIVE_FIRST   = 64,
    parameter int unsigned ACTIVE_LINES   = 128,
    parameter int unsigned INT_LEAD       = 2,
    parameter int unsigned EF_LINES       = 4,
    parameter int unsigned FB_AW          = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic [1:0]       SC,
    input  logic             disp_on,
    input  logic             disp_off,
    input  logic             line_start,
    input  logic [8:0]       vpos,
    input  logic [7:0]       data_in,
    output logic             DMAO,
    output logic             INT,
    output logic             EFx,
    output logic             fb_wr_en,
    output logic [FB_AW-1:0] fb_wr_addr,
    output logic [7:0]       fb_wr_data,
    output logic             enabled,
    output logic             overrun
);

    localparam int unsigned CNT_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;

    localparam logic [8:0]       V_FIRST  = 9'(ACTIVE_FIRST);
    localparam logic [8:0]       V_LAST   = 9'(ACTIVE_FIRST + ACTIVE_LINES - 1);
    localparam logic [8:0]       V_INT    = 9'(ACTIVE_FIRST - INT_LEAD);
    localparam logic [8:0]       V_EF0    = 9'(ACTIVE_FIRST - EF_LINES);
    localparam logic [8:0]       V_EF1    = 9'(ACTIVE_FIRST + ACTIVE_LINES - EF_LINES);
    localparam logic [8:0]       V_END    = 9'(ACTIVE_FIRST + ACTIVE_LINES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        BURST     = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               enabled_q, enabled_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               dmao_q, dmao_d;
    logic               int_q, int_d;
    logic               efx_q, efx_d;
    logic               wr_en_q, wr_en_d;
    logic [FB_AW-1:0]   addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               overrun_q, overrun_d;

    logic dma_cycle;
    logic ack_cycle;
    logic active_line;
    logic start_line;
    logic accept;

    // Input qualification shared by the FSM and output logic
    always_comb begin
        dma_cycle   = clk_enable && (SC == 2'b10);
        ack_cycle   = clk_enable && (SC == 2'b11);
        active_line = line_start && (vpos >= V_FIRST) && (vpos <= V_LAST);
    end

    // Enable control; disp_on wins over disp_off
    always_comb begin
        enabled_d = enabled_q;
        if (clk_enable && disp_on) begin
            enabled_d = 1'b1;
        end else if (clk_enable && disp_off) begin
            enabled_d = 1'b0;
        end
    end

    // A line_start always ends the current burst, so a byte on that cycle is dropped.
    // Disabling takes effect on the same edge, so no write follows disp_off.
    always_comb begin
        start_line = enabled_d && active_line && (state_q != IDLE);
        accept     = enabled_d && (state_q == BURST) && !line_start && dma_cycle;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!enabled_d) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enabled_q) begin
                        state_d = WAIT_LINE;
                    end
                end
                WAIT_LINE: begin
                    if (active_line) begin
                        state_d = BURST;
                    end
                end
                BURST: begin
                    if (line_start) begin
                        state_d = active_line ? BURST : WAIT_LINE;
                    end else if (accept && (byte_cnt_q == CNT_LAST)) begin
                        state_d = WAIT_LINE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output next-values; all outputs are registered below
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        wr_en_d    = 1'b0;
        data_d     = data_q;
        addr_d     = addr_q;
        int_d      = int_q;
        efx_d      = efx_q;
        overrun_d  = overrun_q;
        dmao_d     = (state_d != BURST);

        if (start_line) begin
            byte_cnt_d = '0;
        end else if (accept) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end

        if (accept) begin
            wr_en_d = 1'b1;
            data_d  = data_in;
        end

        // Address advances the cycle after each strobe; a new frame restarts at 0
        if (start_line && (vpos == V_FIRST)) begin
            addr_d = '0;
        end else if (wr_en_q) begin
            addr_d = addr_q + FB_AW'(1);
        end

        if ((state_q == BURST) && line_start && enabled_d) begin
            overrun_d = 1'b1;
        end

        // Clearing wins over setting; INT is held low while disabled
        if (line_start && (vpos == V_INT)) begin
            int_d = 1'b1;
        end
        if ((line_start && (vpos == V_FIRST)) || ack_cycle || !enabled_d) begin
            int_d = 1'b0;
        end

        if (line_start) begin
            if ((vpos == V_EF0) || (vpos == V_EF1)) begin
                efx_d = 1'b0;
            end else if ((vpos == V_FIRST) || (vpos == V_END)) begin
                efx_d = 1'b1;
            end
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            enabled_q  <= 1'b0;
            byte_cnt_q <= '0;
            dmao_q     <= 1'b1;
            int_q      <= 1'b0;
            efx_q      <= 1'b1;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            enabled_q  <= enabled_d;
            byte_cnt_q <= byte_cnt_d;
            dmao_q     <= dmao_d;
            int_q      <= int_d;
            efx_q      <= efx_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign DMAO       = dmao_q;
    assign INT        = int_q;
    assign EFx        = efx_q;
    assign fb_wr_en   = wr_en_q;
    assign fb_wr_addr = addr_q;
    assign fb_wr_data = data_q;
    assign enabled    = enabled_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pixie_dma_sched.sv
// Testbench for pixie_dma_sched: frame-level stimulus with a behavioural
// model of lines, bursts, the frame-buffer address and the INT/EFx windows.
module tb_pixie_dma_sched;

    localparam int N_LINES   = 200;
    localparam int LINE_CLKS = 24;

    localparam int M_FULL  = 0;
    localparam int M_TRUNC = 1;
    localparam int M_ACK   = 2;
    localparam int M_RAND  = 3;
    localparam int M_OFF   = 4;
    localparam int M_DIS   = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_enable;
    logic [1:0] SC;
    logic       disp_on;
    logic       disp_off;
    logic       line_start;
    logic [8:0] vpos;
    logic [7:0] data_in;
    logic       DMAO;
    logic       INT;
    logic       EFx;
    logic       fb_wr_en;
    logic [9:0] fb_wr_addr;
    logic [7:0] fb_wr_data;
    logic       enabled;
    logic       overrun;

    always #5 clk = ~clk;

    pixie_dma_sched dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .SC         (SC),
        .disp_on    (disp_on),
        .disp_off   (disp_off),
        .line_start (line_start),
        .vpos       (vpos),
        .data_in    (data_in),
        .DMAO       (DMAO),
        .INT        (INT),
        .EFx        (EFx),
        .fb_wr_en   (fb_wr_en),
        .fb_wr_addr (fb_wr_addr),
        .fb_wr_data (fb_wr_data),
        .enabled    (enabled),
        .overrun    (overrun)
    );

    int n_vec = 0;
    int n_err = 0;
    int wr_count = 0;
    int line_wr = 0;
    bit int_seen = 1'b0;

    // Reference model: display on/off, armed after one settle cycle, burst per active line
    bit        m_en, m_armed, m_burst, m_int, m_efx, m_ovr, m_wr;
    int        m_left, m_next, m_wa;
    logic [7:0] m_wd;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_armed = 0; m_burst = 0; m_int = 0; m_efx = 1; m_ovr = 0; m_wr = 0;
        m_left = 0; m_next = 0; m_wa = 0; m_wd = 8'h00;
    endtask

    task automatic model_step();
        bit en_n;
        bit active;
        int vp;
        vp = int'(vpos);
        en_n = m_en;
        if (clk_enable && disp_on) en_n = 1;
        else if (clk_enable && disp_off) en_n = 0;
        active = line_start && (vp >= 64) && (vp <= 191);
        m_wr = 0;
        if (!en_n) begin
            m_burst = 0;
            m_armed = 0;
        end else if (!m_armed) begin
            m_armed = m_en;
        end else begin
            if (m_burst && line_start) begin
                m_ovr = 1;
                m_burst = 0;
            end
            if (m_burst) begin
                if (clk_enable && SC == 2'b10) begin
                    m_wr = 1;
                    m_wa = m_next;
                    m_wd = data_in;
                    m_next = (m_next + 1) % 1024;
                    m_left--;
                    if (m_left == 0) m_burst = 0;
                end
            end else if (active) begin
                m_burst = 1;
                m_left = 8;
                if (vp == 64) m_next = 0;
            end
        end
        if (line_start) begin
            if (vp == 62 && en_n) m_int = 1;
            if (vp == 64) m_int = 0;
            m_efx = !(((vp >= 60) && (vp < 64)) || ((vp >= 188) && (vp < 192)));
        end
        if (clk_enable && SC == 2'b11) m_int = 0;
        if (!en_n) m_int = 0;
        m_en = en_n;
    endtask

    task automatic idle_inputs();
        clk_enable = 1'b0;
        SC         = 2'b00;
        disp_on    = 1'b0;
        disp_off   = 1'b0;
        line_start = 1'b0;
        data_in    = 8'($urandom);
    endtask

    // One clock: advance, update model, compare away from the edge
    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        check_val("ctrl", 32'({DMAO, INT, EFx, enabled, overrun, fb_wr_en}),
                  32'({!m_burst, m_int, m_efx, m_en, m_ovr, m_wr}));
        check_val("addr", 32'(fb_wr_addr), m_wr ? 32'(m_wa) : 32'(m_next));
        if (m_wr) check_val("data", 32'(fb_wr_data), 32'(m_wd));
        if (fb_wr_en) begin
            wr_count++;
            line_wr++;
        end
        if (INT) int_seen = 1'b1;
    endtask

    task automatic run_frame(input int mode, input int special);
        int answered;
        bit off_done;
        bit off_now;
        for (int l = 0; l < N_LINES; l++) begin
            answered = 0;
            off_done = 0;
            line_wr  = 0;
            for (int c = 0; c < LINE_CLKS; c++) begin
                idle_inputs();
                off_now    = 0;
                line_start = (c == 0);
                vpos       = 9'(l);
                if (mode == M_RAND) clk_enable = 1'($urandom_range(0, 1));
                else clk_enable = (c % 2 == 1);
                if (clk_enable) begin
                    if (mode == M_OFF && l == special && answered == 3 && !off_done) begin
                        disp_off = 1'b1;
                        SC       = 2'b01;
                        off_done = 1;
                        off_now  = 1;
                    end else if (!DMAO && !off_done
                                 && !(mode == M_TRUNC && l == special && answered >= 5)
                                 && (mode != M_RAND || $urandom_range(0, 99) < 70)) begin
                        SC = 2'b10;
                        answered++;
                    end else if (mode == M_ACK && l == 63 && c == 1) begin
                        SC = 2'b11;
                    end else if (mode == M_RAND) begin
                        SC = ($urandom_range(0, 99) < 5) ? 2'b11 : 2'($urandom_range(0, 2));
                    end
                end
                step();
                if (off_now) begin
                    check_val("off_dmao", 32'(DMAO), 32'd1);
                    check_val("off_enabled", 32'(enabled), 32'd0);
                end
                if (mode == M_FULL && l == 62 && c == 2) check_val("int_l62", 32'(INT), 32'd1);
                if (mode == M_FULL && l == 64 && c == 1) check_val("int_l64", 32'(INT), 32'd0);
                if (mode == M_ACK && l == 63 && c == 0) check_val("int_pre_ack", 32'(INT), 32'd1);
                if (mode == M_ACK && l == 63 && c == 1) check_val("int_ack", 32'(INT), 32'd0);
                if ((mode == M_FULL || mode == M_DIS) && c == 1
                    && (l == 59 || l == 60 || l == 63 || l == 64 || l == 188 || l == 191 || l == 192))
                    check_val("efx_win", 32'(EFx),
                              (((l >= 60) && (l <= 63)) || ((l >= 188) && (l <= 191))) ? 32'd0 : 32'd1);
            end
            if (mode == M_TRUNC && l == special) check_val("trunc_writes", 32'(line_wr), 32'd5);
            if (mode == M_OFF && l == special) check_val("off_writes", 32'(line_wr), 32'd3);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        vpos = 9'd0;
        repeat (3) step();
        check_val("rst_dmao", 32'(DMAO), 32'd1);
        check_val("rst_efx", 32'(EFx), 32'd1);
        check_val("rst_addr", 32'(fb_wr_addr), 32'd0);
        reset = 1'b0;

        idle_inputs();
        clk_enable = 1'b1;
        disp_on    = 1'b1;
        disp_off   = 1'b1;
        step();
        check_val("on_wins", 32'(enabled), 32'd1);

        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            clk_enable = 1'b1;
            SC         = 2'b10;
            step();
            check_val("no_wr_dmao_hi", 32'(fb_wr_en), 32'd0);
        end

        wr_count = 0;
        run_frame(M_FULL, 0);
        check_val("frame_writes", 32'(wr_count), 32'd1024);
        check_val("addr_wrap", 32'(fb_wr_addr), 32'd0);
        check_val("no_overrun", 32'(overrun), 32'd0);

        run_frame(M_TRUNC, 100);
        check_val("overrun_set", 32'(overrun), 32'd1);

        run_frame(M_ACK, 0);
        run_frame(M_RAND, 0);
        run_frame(M_OFF, 70);
        check_val("disabled", 32'(enabled), 32'd0);

        wr_count = 0;
        int_seen = 1'b0;
        run_frame(M_DIS, 0);
        check_val("dis_int", 32'(int_seen), 32'd0);
        check_val("dis_writes", 32'(wr_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
